// File: rtl/burst_rom_pkg.sv
// ----------------------------------------------------------------------------
// burst_rom_pkg
// Shared types and constants for the burst byte ROM:
//   state_t        - burst FSM states (IDLE, BURST)
//   DEFAULT_WORDS  - reference 8 x 64-bit table (quantisation coefficients)
//   rom_word()     - builds ROM word idx for an arbitrary word width, returned
//                    right-aligned in a MAX_WORD_W-bit vector
// ----------------------------------------------------------------------------
package burst_rom_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Widest word rom_word() can build; WORD_BYTES must not exceed this.
    localparam int MAX_WORD_BYTES = 32;
    localparam int MAX_WORD_W     = MAX_WORD_BYTES * 8;

    localparam logic [63:0] DEFAULT_WORDS [8] = '{
        64'hFF806C5D4F4C473C,
        64'h80805D554C473C37,
        64'h6C5D4F4C473C3C36,
        64'h5D5D4F4C473C3733,
        64'h5D4F4C47403B332B,
        64'h4F4C47403B332B23,
        64'h4F4C473C362D251E,
        64'h4C473B362D251E19
    };

    // Byte j of the built word (byte 0 = MSB) is byte (j mod 8) of the default
    // word. This one rule covers both cases: narrower words keep the MSB end
    // (truncation from the LSB side), wider words repeat the 8-byte pattern.
    function automatic logic [MAX_WORD_W-1:0] rom_word(input int unsigned idx,
                                                       input int unsigned word_bytes);
        logic [MAX_WORD_W-1:0] w;
        logic [63:0]           src;
        w   = '0;
        src = DEFAULT_WORDS[idx % 8];
        for (int unsigned j = 0; j < word_bytes; j++) begin
            w[(word_bytes - 1 - j) * 8 +: 8] = src[(7 - (j % 8)) * 8 +: 8];
        end
        return w;
    endfunction

endpackage

// File: rtl/rom_byte_lookup.sv
// ----------------------------------------------------------------------------
// rom_byte_lookup
// Combinational byte read from the constant ROM table.
//   addr [ADDR_W] in  - byte address: upper bits select the word, lower bits
//                       select the byte (byte 0 = most significant byte)
//   data [8]      out - addressed byte
// ----------------------------------------------------------------------------
module rom_byte_lookup
    import burst_rom_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int WORD_BYTES = 8,
    parameter int ADDR_W     = $clog2(DEPTH * WORD_BYTES)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [7:0]        data
);

    localparam int BYTE_W = $clog2(WORD_BYTES);
    localparam int WORD_W = WORD_BYTES * 8;

    logic [WORD_W-1:0]        rom_words [DEPTH];
    logic [ADDR_W-BYTE_W-1:0] word_idx;
    logic [BYTE_W-1:0]        byte_idx;
    logic [WORD_W-1:0]        word_sel;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            localparam logic [MAX_WORD_W-1:0] FULL_WORD = rom_word(gi, WORD_BYTES);
            assign rom_words[gi] = FULL_WORD[WORD_W-1:0];
        end
    endgenerate

    assign word_idx = addr[ADDR_W-1:BYTE_W];
    assign byte_idx = addr[BYTE_W-1:0];
    assign word_sel = rom_words[word_idx];

    always_comb begin
        data = '0;
        for (int j = 0; j < WORD_BYTES; j++) begin
            if (byte_idx == BYTE_W'(j)) begin
                data = word_sel[(WORD_BYTES - 1 - j) * 8 +: 8];
            end
        end
    end

endmodule

// File: rtl/burst_byte_rom.sv
// ----------------------------------------------------------------------------
// burst_byte_rom
// Byte-addressable constant ROM streaming req_len+1 consecutive bytes per
// accepted request, with output backpressure, abort and address wrap-around.
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_ready   - request handshake (ready only while IDLE)
//   req_addr [ADDR_W]     - start byte address
//   req_len  [LEN_W]      - burst length minus one
//   abort                 - cancels a burst in progress (ignored in IDLE)
//   dout/dout_valid/dout_ready/dout_last - byte stream, registered
//   busy                  - high while a burst is in progress
// ----------------------------------------------------------------------------
module burst_byte_rom
    import burst_rom_pkg::*;
#(
    parameter  int DEPTH      = 8,
    parameter  int WORD_BYTES = 8,
    parameter  int LEN_W      = 4,
    localparam int ADDR_W     = $clog2(DEPTH * WORD_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              abort,
    output logic [7:0]        dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              busy
);

    state_t            state_reg, state_next;
    logic [7:0]        dout_reg, dout_next;
    logic              dout_valid_reg, dout_valid_next;
    logic              dout_last_reg, dout_last_next;
    logic [ADDR_W-1:0] cur_addr_reg, cur_addr_next;
    logic [LEN_W-1:0]  left_reg, left_next;
    logic              req_ready_reg, busy_reg;

    logic [ADDR_W-1:0] lookup_addr;
    logic [7:0]        lookup_byte;

    // The single lookup serves both the first byte (from the request) and the
    // following bytes (from the running address).
    assign lookup_addr = (state_reg == IDLE) ? req_addr : cur_addr_reg;

    rom_byte_lookup #(
        .DEPTH      (DEPTH),
        .WORD_BYTES (WORD_BYTES),
        .ADDR_W     (ADDR_W)
    ) u_lookup (
        .addr (lookup_addr),
        .data (lookup_byte)
    );

    always_comb begin
        state_next      = state_reg;
        dout_next       = dout_reg;
        dout_valid_next = dout_valid_reg;
        dout_last_next  = dout_last_reg;
        cur_addr_next   = cur_addr_reg;
        left_next       = left_reg;

        unique case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    dout_next       = lookup_byte;
                    dout_valid_next = 1'b1;
                    dout_last_next  = (req_len == '0);
                    // Address width equals the ROM size, so +1 wraps naturally.
                    cur_addr_next   = req_addr + ADDR_W'(1);
                    left_next       = req_len;
                    state_next      = BURST;
                end
            end
            BURST: begin
                if (abort) begin
                    dout_valid_next = 1'b0;
                    dout_last_next  = 1'b0;
                    state_next      = IDLE;
                end else if (dout_valid_reg && dout_ready) begin
                    if (left_reg != '0) begin
                        dout_next      = lookup_byte;
                        cur_addr_next  = cur_addr_reg + ADDR_W'(1);
                        left_next      = left_reg - LEN_W'(1);
                        dout_last_next = (left_reg == LEN_W'(1));
                    end else begin
                        dout_valid_next = 1'b0;
                        dout_last_next  = 1'b0;
                        state_next      = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            dout_last_reg  <= 1'b0;
            cur_addr_reg   <= '0;
            left_reg       <= '0;
            req_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            dout_last_reg  <= dout_last_next;
            cur_addr_reg   <= cur_addr_next;
            left_reg       <= left_next;
            // Flopped copies of the state decode so every output is a register.
            req_ready_reg  <= (state_next == IDLE);
            busy_reg       <= (state_next == BURST);
        end
    end

    assign req_ready  = req_ready_reg;
    assign busy       = busy_reg;
    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign dout_last  = dout_last_reg;

endmodule

// File: doc/burst_byte_rom.md
Name: burst_byte_rom

Overview:
Parametrised byte-addressable ROM. Generalises the fixed 8-word x 64-bit, 1-byte-read ROM to configurable depth and word width. Adds a valid/ready request port and multi-byte bursts with backpressure, an abort input and address wrap-around. Used by table-driven blocks (quantisation/coefficient tables) that stream consecutive bytes from one request.

Parameters:
DEPTH, 8, number of ROM words; power of two, >= 2
WORD_BYTES, 8, bytes per word; power of two, >= 2
LEN_W, 4, width of burst length field; burst = req_len+1 bytes (1..2^LEN_W)
ADDR_W, $clog2(DEPTH*WORD_BYTES), byte address width (derived, localparam)

Ports:
clk  in  1  rising-edge clock, single clock domain
rst  in  1  synchronous, active-high reset
req_valid  in  1  burst request present
req_ready  out  1  block can accept a request
req_addr  in  ADDR_W  start byte address
req_len  in  LEN_W  bytes-1 to stream
abort  in  1  cancel current burst
dout  out  8  read byte
dout_valid  out  1  dout holds a valid byte
dout_ready  in  1  consumer accepts dout
dout_last  out  1  dout is the final byte of the burst
busy  out  1  burst in progress (state BURST)

Behaviour:
- Address map: word = addr[ADDR_W-1:log2(WORD_BYTES)], byte = addr[log2(WORD_BYTES)-1:0]. Byte 0 is the most significant byte of the word.
- Default contents (DEPTH=8, WORD_BYTES=8), words 0..7:
  FF806C5D4F4C473C, 80805D554C473C37, 6C5D4F4C473C3C36, 5D5D4F4C473C3733, 5D4F4C47403B332B, 4F4C47403B332B23, 4F4C473C362D251E, 4C473B362D251E19.
  For other sizes: word i = default word (i mod 8), truncated from the LSB end or replicated to fill WORD_BYTES.
- All outputs are registered. On reset: state IDLE, dout=0, dout_valid=0, dout_last=0, busy=0, req_ready=1, internal address and count = 0.
- FSM states: IDLE, BURST.
- IDLE: req_ready=1.
  - req_valid handshake: dout <= byte(req_addr); dout_valid <= 1; dout_last <= (req_len==0); cur_addr <= req_addr+1; left <= req_len; go to BURST.
  - Latency: first byte is valid the cycle after acceptance.
- BURST: req_ready=0; busy=1; new requests are ignored until IDLE.
  - On dout_valid && dout_ready with left>0: dout <= byte(cur_addr); cur_addr++; left--; dout_last <= (left==1).
  - On dout_valid && dout_ready with left==0: dout_valid <= 0, dout_last <= 0, go to IDLE. req_ready rises the following cycle; no back-to-back overlap.
  - dout_ready=0: dout, dout_valid and dout_last hold stable and the address does not advance.
- Wrap-around: cur_addr increments modulo DEPTH*WORD_BYTES. The last byte of the last word is followed by byte 0 of word 0.
- abort (BURST only, highest priority after rst): next cycle dout_valid=0, dout_last=0, state IDLE. Any byte pending handshake in that cycle is discarded. abort in IDLE has no effect.
- rst mid-burst: immediate return to reset values at the next edge. No partial output.
- dout holds its last value when dout_valid=0; consumers qualify it with dout_valid.

Decomposition:
- Package burst_rom_pkg:
  - state enum {IDLE, BURST}
  - default 8-entry 64-bit contents constant
  - function rom_word(idx, WORD_BYTES) building each word
- Sub-module rom_byte_lookup: combinational word + byte select from the byte address (parametrised DEPTH, WORD_BYTES). Instantiated once.
- Top level holds the FSM, counters and output register.

Test Plan:
- Reset, then req addr=0 len=0, dout_ready=1 -> next cycle dout=FF, valid=1, last=1; following cycle valid=0, req_ready=1.
- req addr=6 len=3, dout_ready=1 -> dout 47,3C,80,80 on consecutive cycles; last only on the 4th; busy high for 4 cycles.
- Wrap: req addr=63 len=1 -> dout 19 then FF; last on FF.
- Backpressure: addr=8 len=2, dout_ready low for 3 cycles after the first byte -> 80 held stable with valid=1; then 80,5D delivered once each, no skips or duplicates.
- Abort: addr=16 len=7, abort asserted on the 3rd byte (4F) -> next cycle valid=0, busy=0, req_ready=1; a new req addr=0 len=0 returns FF.
- Reset mid-burst, and req_valid during BURST: rst asserted on the 2nd byte gives all outputs at reset values next cycle. req_valid held high during a burst is not accepted until the first IDLE cycle.
